// File: rtl/icache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl_pkg
// Description : Shared sizing constants and FSM state encodings for the
//               direct-mapped instruction cache and its refill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_ctrl_pkg;

  // Widths shared with the rest of the core and the memory controller
  localparam int ADDR_WID             = 32;
  localparam int MEM_CTRL_IF_DATA_LEN = 16;  // bytes per refill beat == line size
  localparam int IF_DATA_WID          = 32;  // instruction word width

  // Cache geometry
  localparam int ICACHE_SET_NUM = 16;
  localparam int ICACHE_IDX_WID = $clog2(ICACHE_SET_NUM);

  // Refill sequencer state encoding
  typedef logic [0:0] icache_state_t;
  localparam logic [0:0] ICACHE_IDLE = 1'b0;
  localparam logic [0:0] ICACHE_MISS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/icache_word_sel.sv
`default_nettype none
// ============================================================================
// Module      : icache_word_sel
// Description : Combinational mux returning one little-endian 32-bit word of
//               a cache line, selected by the byte offset of the fetch PC.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_word_sel
  import icache_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = MEM_CTRL_IF_DATA_LEN
) (
  input  logic [LINE_BYTES*8-1:0]       line,
  input  logic [$clog2(LINE_BYTES)-1:0] offset,
  output logic [IF_DATA_WID-1:0]        word
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int WORDS = LINE_BYTES / 4;

  generate
    if (LINE_BYTES == 4) begin : g_single
      // A one-word line needs no selection; the offset only addresses bytes
      logic w_unused;
      assign w_unused = &{1'b0, offset};
      assign word     = line;
    end else begin : g_multi
      logic          w_unused;
      logic [OFF-3:0] w_word_idx;

      // Byte-within-word bits are always zero for aligned fetches
      assign w_unused   = &{1'b0, offset[1:0]};
      assign w_word_idx = offset[OFF-1:2];

      // Pick the addressed word; byte i of the line sits at [8i+7:8i]
      always_comb begin
        word = '0;
        for (int i = 0; i < WORDS; i++) begin
          if (w_word_idx == i[OFF-3:0]) begin
            word = line[i*IF_DATA_WID +: IF_DATA_WID];
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl
// Description : Direct-mapped instruction cache with a single-outstanding
//               line refill sequencer toward the memory controller fetch port.
//               Lookup is purely combinational and works during a refill.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = MEM_CTRL_IF_DATA_LEN,
  parameter int SET_NUM    = ICACHE_SET_NUM,
  parameter int ADDR_W     = ADDR_WID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fe_req,
  input  logic [ADDR_W-1:0]       fe_pc,
  output logic                    fe_hit,
  output logic [IF_DATA_WID-1:0]  fe_inst,
  output logic                    mc_en,
  output logic [ADDR_W-1:0]       mc_pc,
  input  logic                    mc_done,
  input  logic [LINE_BYTES*8-1:0] mc_data
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(SET_NUM);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int LINE_W = LINE_BYTES * 8;

  icache_state_t     r_state;
  logic              r_mc_en;
  logic [ADDR_W-1:0] r_mc_pc;
  logic [SET_NUM-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag  [SET_NUM];
  logic [LINE_W-1:0] r_data [SET_NUM];

  logic [IDX-1:0]    w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX-1:0]    w_ridx;
  logic [TAG_W-1:0]  w_rtag;
  logic              w_hit;
  logic              w_fill;

  // Fetch address split
  assign w_idx  = fe_pc[OFF+IDX-1:OFF];
  assign w_tag  = fe_pc[ADDR_W-1:OFF+IDX];

  // Refill target comes from the latched line address, never from fe_pc
  assign w_ridx = r_mc_pc[OFF+IDX-1:OFF];
  assign w_rtag = r_mc_pc[ADDR_W-1:OFF+IDX];

  // Lookup ignores the FSM so resident lines keep hitting during a refill
  assign w_hit  = fe_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign fe_hit = w_hit;

  // A completed refill is accepted only while waiting for one
  assign w_fill = ~rst & rdy & (r_state == ICACHE_MISS) & mc_done;

  assign mc_en  = r_mc_en;
  assign mc_pc  = r_mc_pc;

  icache_word_sel #(
    .LINE_BYTES (LINE_BYTES)
  ) u_word_sel (
    .line   (r_data[w_idx]),
    .offset (fe_pc[OFF-1:0]),
    .word   (fe_inst)
  );

  // Refill sequencer: launch one line fetch per miss, install on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ICACHE_IDLE;
      r_mc_en <= 1'b0;
      r_mc_pc <= '0;
      r_valid <= '0;
    end else if (rdy) begin
      case (r_state)
        ICACHE_IDLE: begin
          // A flushed request must not pull a line the pipeline no longer wants
          if (fe_req && !w_hit && !rollback) begin
            r_mc_pc <= {fe_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
            r_mc_en <= 1'b1;
            r_state <= ICACHE_MISS;
          end
        end
        ICACHE_MISS: begin
          // The memory controller cannot cancel, so rollback is ignored here
          if (mc_done) begin
            r_valid[w_ridx] <= 1'b1;
            r_mc_en         <= 1'b0;
            r_state         <= ICACHE_IDLE;
          end
        end
        default: r_state <= ICACHE_IDLE;
      endcase
    end
  end

  // Tag and data arrays are qualified by valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_ridx]  <= w_rtag;
      r_data[w_ridx] <= mc_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_ctrl
// Description : Self-checking bench for icache_ctrl: a directed vector table
//               covering the refill corner cases, then randomized traffic
//               compared against a line-level behavioural cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  localparam int LB = 16;
  localparam int SN = ICACHE_SET_NUM;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback, fe_req, mc_done;
  logic [31:0]  fe_pc;
  logic [127:0] mc_data;
  logic         fe_hit, mc_en;
  logic [31:0]  fe_inst, mc_pc;

  int total = 0;
  int bad   = 0;

  icache_ctrl #(
    .LINE_BYTES (LB),
    .SET_NUM    (SN),
    .ADDR_W     (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .fe_req   (fe_req),
    .fe_pc    (fe_pc),
    .fe_hit   (fe_hit),
    .fe_inst  (fe_inst),
    .mc_en    (mc_en),
    .mc_pc    (mc_pc),
    .mc_done  (mc_done),
    .mc_data  (mc_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, rb, req;
    logic [31:0] pc;
    logic        done;
    logic [7:0]  seed;
    logic        hit;
    logic [31:0] inst;
    logic        en;
    logic [31:0] mcpc;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Line whose byte i is seed+i
  function automatic logic [127:0] mkline(input logic [7:0] s);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = s + 8'(i);
    return l;
  endfunction

  // Backing memory contents for the random phase
  function automatic logic [127:0] mem_line(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++)
      l[i*32 +: 32] = (base * 32'h9E37_79B1) + (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
    return l;
  endfunction

  task automatic add(input logic r, input logic y, input logic b, input logic q,
                     input logic [31:0] pc, input logic d, input logic [7:0] s,
                     input logic h, input logic [31:0] ins, input logic e,
                     input logic [31:0] mp);
    vec_t v;
    v.rst = r; v.rdy = y; v.rb = b; v.req = q; v.pc = pc; v.done = d; v.seed = s;
    v.hit = h; v.inst = ins; v.en = e; v.mcpc = mp;
    vt.push_back(v);
  endtask

  // Behavioural model state (line granularity)
  bit           m_valid [SN];
  int unsigned  m_tag   [SN];
  logic [127:0] m_line  [SN];
  bit           m_miss;
  logic [31:0]  m_base;
  int           wait_cnt;

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; fe_req = 1'b0;
    fe_pc = 32'h0; mc_done = 1'b0; mc_data = '0;

    //   rst rdy rb req pc           done seed   hit inst          en mcpc
    add(0, 1, 0, 1, 32'h0000_1004, 0, 8'h00, 0, 32'h0,          0, 32'h0);
    add(0, 1, 0, 1, 32'h0000_1004, 0, 8'h00, 0, 32'h0,          1, 32'h1000);
    add(0, 1, 0, 1, 32'h0000_1004, 1, 8'h00, 0, 32'h0,          1, 32'h1000);
    add(0, 1, 0, 1, 32'h0000_1004, 0, 8'h00, 1, 32'h0706_0504,  0, 32'h1000);
    add(0, 1, 0, 1, 32'h0000_1008, 0, 8'h00, 1, 32'h0B0A_0908,  0, 32'h1000);
    add(0, 1, 0, 1, 32'h0000_100C, 0, 8'h00, 1, 32'h0F0E_0D0C,  0, 32'h1000);
    add(0, 1, 0, 1, 32'h0000_1100, 0, 8'h00, 0, 32'h0,          0, 32'h1000);
    add(0, 1, 0, 0, 32'h0000_1100, 0, 8'h00, 0, 32'h0,          1, 32'h1100);
    add(0, 1, 0, 0, 32'h0000_1100, 1, 8'h40, 0, 32'h0,          1, 32'h1100);
    add(0, 1, 0, 1, 32'h0000_1104, 0, 8'h00, 1, 32'h4746_4544,  0, 32'h1100);
    add(0, 1, 0, 1, 32'h0000_1000, 0, 8'h00, 0, 32'h0,          0, 32'h1100);
    add(0, 1, 1, 1, 32'h0000_2000, 0, 8'h00, 0, 32'h0,          1, 32'h1000);
    add(0, 1, 1, 1, 32'h0000_2000, 0, 8'h00, 0, 32'h0,          1, 32'h1000);
    add(0, 1, 1, 1, 32'h0000_2000, 1, 8'h00, 0, 32'h0,          1, 32'h1000);
    add(0, 1, 0, 1, 32'h0000_2000, 0, 8'h00, 0, 32'h0,          0, 32'h1000);
    add(0, 1, 0, 1, 32'h0000_1000, 0, 8'h00, 1, 32'h0302_0100,  1, 32'h2000);
    add(0, 1, 0, 0, 32'h0000_1000, 1, 8'h80, 0, 32'h0,          1, 32'h2000);
    add(0, 1, 0, 1, 32'h0000_2004, 0, 8'h00, 1, 32'h8786_8584,  0, 32'h2000);
    add(0, 1, 0, 1, 32'h0000_3000, 0, 8'h00, 0, 32'h0,          0, 32'h2000);
    add(0, 1, 0, 1, 32'h0000_2004, 0, 8'h00, 1, 32'h8786_8584,  1, 32'h3000);
    add(0, 0, 0, 1, 32'h0000_2004, 0, 8'h00, 1, 32'h8786_8584,  1, 32'h3000);
    add(0, 0, 0, 0, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          1, 32'h3000);
    add(0, 0, 0, 0, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          1, 32'h3000);
    add(0, 0, 0, 0, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          1, 32'h3000);
    add(0, 0, 0, 0, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          1, 32'h3000);
    add(0, 1, 0, 0, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          1, 32'h3000);
    add(1, 1, 0, 0, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          1, 32'h3000);
    add(0, 1, 0, 0, 32'h0000_2004, 1, 8'h55, 0, 32'h0,          0, 32'h0);
    add(0, 1, 1, 1, 32'h0000_1000, 0, 8'h00, 0, 32'h0,          0, 32'h0);
    add(0, 1, 0, 1, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          0, 32'h0);
    add(0, 1, 0, 0, 32'h0000_2004, 0, 8'h00, 0, 32'h0,          1, 32'h2000);
    add(0, 1, 0, 0, 32'h0000_2004, 1, 8'hA0, 0, 32'h0,          1, 32'h2000);
    add(0, 1, 0, 1, 32'h0000_3000, 0, 8'h00, 0, 32'h0,          0, 32'h2000);
    add(0, 1, 0, 1, 32'h0000_2000, 0, 8'h00, 1, 32'hA3A2_A1A0,  1, 32'h3000);

    repeat (2) @(posedge clk);
    #1;

    // Directed table: drive just after the edge, check mid-cycle
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; rdy = vt[i].rdy; rollback = vt[i].rb; fe_req = vt[i].req;
      fe_pc = vt[i].pc; mc_done = vt[i].done; mc_data = mkline(vt[i].seed);
      #4;
      chk($sformatf("v%0d_hit", i), {31'b0, fe_hit}, {31'b0, vt[i].hit});
      if (vt[i].hit) chk($sformatf("v%0d_inst", i), fe_inst, vt[i].inst);
      chk($sformatf("v%0d_mc_en", i), {31'b0, mc_en}, {31'b0, vt[i].en});
      chk($sformatf("v%0d_mc_pc", i), mc_pc, vt[i].mcpc);
      @(posedge clk);
      #1;
    end

    // Randomized phase against the behavioural model
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; fe_req = 1'b0; mc_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < SN; s++) m_valid[s] = 1'b0;
    m_miss = 1'b0; m_base = 32'h0; wait_cnt = 0;

    for (int c = 0; c < 3000; c++) begin
      int unsigned idx, tag, w;
      logic        e_hit;

      rst      = ($urandom_range(0, 299) == 0);
      rdy      = rst ? 1'b1 : ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 9) == 0);
      fe_req   = ($urandom_range(0, 9) < 7);
      fe_pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                 (32'($urandom_range(0, 3)) << 2) |
                 (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0);
      if (m_miss && wait_cnt == 0) begin
        mc_done = 1'b1;
        mc_data = mem_line(m_base);
      end else begin
        mc_done = (!m_miss && $urandom_range(0, 29) == 0);
        mc_data = {$urandom, $urandom, $urandom, $urandom};
      end
      #4;

      idx   = (fe_pc / LB) % ((1 << ICACHE_IDX_WID));
      tag   = fe_pc / (LB * SN);
      w     = (fe_pc % LB) / 4;
      e_hit = fe_req && m_valid[idx] && (m_tag[idx] == tag);
      chk("rnd_hit", {31'b0, fe_hit}, {31'b0, e_hit});
      if (e_hit) chk("rnd_inst", fe_inst, m_line[idx][w*32 +: 32]);
      chk("rnd_mc_en", {31'b0, mc_en}, {31'b0, m_miss});
      chk("rnd_mc_pc", mc_pc, m_base);

      // Advance the model to what the next edge should produce
      if (rst) begin
        for (int s = 0; s < SN; s++) m_valid[s] = 1'b0;
        m_miss = 1'b0;
        m_base = 32'h0;
      end else if (rdy) begin
        if (!m_miss) begin
          if (fe_req && !e_hit && !rollback) begin
            m_miss   = 1'b1;
            m_base   = fe_pc & ~32'(LB - 1);
            wait_cnt = $urandom_range(0, 3);
          end
        end else if (mc_done) begin
          m_valid[(m_base / LB) % SN] = 1'b1;
          m_tag[(m_base / LB) % SN]   = m_base / (LB * SN);
          m_line[(m_base / LB) % SN]  = mc_data;
          m_miss = 1'b0;
        end
      end
      if (m_miss && wait_cnt > 0) wait_cnt--;

      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
